// File: rtl/multi_reg_file.sv
// ---------------------------------------------------------------------------
// multi_reg_file
//   Register file of 2^ADDR words x SIZE bits with three combinational read
//   ports (A, B, C), one synchronous byte-masked write port, and a program
//   counter that is either loaded or auto-incremented by PC_STEP.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   Rst        : synchronous active-high reset (clears registers and PC)
//   M[3:0]     : byte write mask (bit i enables byte i of W_Data)
//   M[4]       : PC auto-increment enable
//   Write_PC   : load PC from PC_New (takes priority over auto-increment)
//   PC_New     : value loaded into PC
//   Write_Reg  : register write enable
//   R_Addr_A/B/C, R_Data_A/B/C : independent combinational read ports
//   W_Addr, W_Data             : write port address / data
//   PC         : current program counter
//
// There is no valid/ready handshake on this block: every input is sampled
// on every rising clk edge, and every output is a continuous function of
// current state and read addresses.
// ---------------------------------------------------------------------------
module multi_reg_file #(
  parameter int ADDR    = 4,
  parameter int SIZE    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic [4:0]      M,
  input  logic            Write_PC,
  input  logic [SIZE-1:0] PC_New,
  input  logic            Write_Reg,
  input  logic [ADDR-1:0] R_Addr_A,
  input  logic [ADDR-1:0] R_Addr_B,
  input  logic [ADDR-1:0] R_Addr_C,
  input  logic [ADDR-1:0] W_Addr,
  input  logic [SIZE-1:0] W_Data,
  output logic [SIZE-1:0] R_Data_A,
  output logic [SIZE-1:0] R_Data_B,
  output logic [SIZE-1:0] R_Data_C,
  output logic [SIZE-1:0] PC
);

  localparam int NUMB   = 2 ** ADDR;
  localparam int NBYTES = SIZE / 8;

  // Storage powers up at zero so the file reads as cleared even before the
  // first reset edge.
  logic [SIZE-1:0] regs [NUMB] = '{default: '0};
  logic [SIZE-1:0] pc_q        = '0;

  // Bit-level write mask expanded from the byte mask. Only four mask bits
  // exist in M, so any byte lanes beyond the fourth are never written.
  logic [SIZE-1:0] bit_mask;

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < 4) begin
        bit_mask[8*i +: 8] = {8{M[i]}};
      end
    end
  end

  // Address 0 is never written, but the read side also forces zero so that
  // register 0 is zero by construction rather than by write discipline.
  always_comb begin
    R_Data_A = (R_Addr_A == '0) ? '0 : regs[R_Addr_A];
    R_Data_B = (R_Addr_B == '0) ? '0 : regs[R_Addr_B];
    R_Data_C = (R_Addr_C == '0) ? '0 : regs[R_Addr_C];
  end

  // Register array. Reads see the pre-edge contents during a write cycle;
  // there is no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (Rst) begin
      for (int r = 0; r < NUMB; r++) begin
        regs[r] <= '0;
      end
    end else if (Write_Reg && (W_Addr != '0)) begin
      regs[W_Addr] <= (regs[W_Addr] & ~bit_mask) | (W_Data & bit_mask);
    end
  end

  // Program counter: load beats auto-increment; increment wraps naturally
  // at SIZE bits.
  always_ff @(posedge clk) begin
    if (Rst) begin
      pc_q <= '0;
    end else if (Write_PC) begin
      pc_q <= PC_New;
    end else if (M[4]) begin
      pc_q <= pc_q + SIZE'(PC_STEP);
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_multi_reg_file.sv
// ---------------------------------------------------------------------------
// tb_multi_reg_file
//   Directed steps followed by randomized cycles for multi_reg_file. A
//   behavioural model (plain array of words plus a PC integer) tracks the
//   expected contents; every check is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_multi_reg_file;

  // ---------------- clock / reset block ----------------
  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic [4:0]  M = '0;
  logic        Write_PC = 1'b0;
  logic [31:0] PC_New = '0;
  logic        Write_Reg = 1'b0;
  logic [3:0]  R_Addr_A = '0, R_Addr_B = '0, R_Addr_C = '0, W_Addr = '0;
  logic [31:0] W_Data = '0;
  logic [31:0] R_Data_A, R_Data_B, R_Data_C, PC;

  always #5 clk = ~clk;

  multi_reg_file #(.ADDR(4), .SIZE(32), .PC_STEP(4)) dut (
    .clk(clk), .Rst(Rst), .M(M), .Write_PC(Write_PC), .PC_New(PC_New),
    .Write_Reg(Write_Reg), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Addr_C(R_Addr_C), .W_Addr(W_Addr), .W_Data(W_Data),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .R_Data_C(R_Data_C), .PC(PC)
  );

  // ---------------- reference model ----------------
  logic [31:0] mreg [16];
  logic [31:0] mpc;
  int vectors     = 0;
  int miscompares = 0;

  // Applies the rules for one rising edge using the inputs as driven.
  task automatic model_edge();
    if (Rst) begin
      for (int r = 0; r < 16; r++) mreg[r] = 32'h0;
      mpc = 32'h0;
    end else begin
      if (Write_Reg && W_Addr != 4'd0) begin
        for (int b = 0; b < 4; b++) begin
          if (M[b]) mreg[W_Addr][8*b +: 8] = W_Data[8*b +: 8];
        end
      end
      if (Write_PC)  mpc = PC_New;
      else if (M[4]) mpc = mpc + 32'd4;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    Rst = 1'b0; M = 5'h00; Write_PC = 1'b0; Write_Reg = 1'b0;
    PC_New = '0; W_Data = '0; W_Addr = '0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [4:0] mode);
    Write_Reg = 1'b1; W_Addr = addr; W_Data = data; M = mode;
    tick();
    idle_inputs();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_a"},  R_Data_A, mreg[R_Addr_A]);
    check({tag, "_b"},  R_Data_B, mreg[R_Addr_B]);
    check({tag, "_c"},  R_Data_C, mreg[R_Addr_C]);
    check({tag, "_pc"}, PC, mpc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < 16; r++) mreg[r] = 32'h0;
    mpc = 32'h0;

    // Reset, then every address reads zero and PC is zero.
    Rst = 1'b1; tick(); idle_inputs(); #1;
    check("reset_pc", PC, 32'h0);
    for (int i = 0; i < 16; i++) begin
      R_Addr_A = 4'(i); R_Addr_B = 4'(i); R_Addr_C = 4'(15 - i); #1;
      check("reset_rd_a", R_Data_A, 32'h0);
      check("reset_rd_b", R_Data_B, 32'h0);
      check("reset_rd_c", R_Data_C, 32'h0);
    end

    // Full write then masked write to register 5.
    R_Addr_A = 4'd5;
    do_write(4'd5, 32'h12345678, 5'h0F); #1;
    check("full_write", R_Data_A, 32'h12345678);
    do_write(4'd5, 32'hAABBCCDD, 5'h05); #1;
    check("masked_write", R_Data_A, 32'h12BB56DD);
    do_write(4'd5, 32'hFFFFFFFF, 5'h00); #1;
    check("zero_mask_write", R_Data_A, 32'h12BB56DD);

    do_write(4'd3, 32'hCAFEF00D, 5'h0F);

    // Register 0 ignores writes.
    do_write(4'd0, 32'hFFFFFFFF, 5'h0F);
    R_Addr_A = 4'd0; R_Addr_B = 4'd0; R_Addr_C = 4'd0; #1;
    check("reg0_a", R_Data_A, 32'h0);
    check("reg0_b", R_Data_B, 32'h0);
    check("reg0_c", R_Data_C, 32'h0);

    // Read during write: old value before the edge, new value after.
    R_Addr_A = 4'd5; R_Addr_B = 4'd5; R_Addr_C = 4'd3;
    Write_Reg = 1'b1; W_Addr = 4'd5; W_Data = 32'h0BADBEEF; M = 5'h0F; #1;
    check("rdw_old_a", R_Data_A, 32'h12BB56DD);
    check("rdw_old_b", R_Data_B, 32'h12BB56DD);
    check("rdw_old_c", R_Data_C, 32'hCAFEF00D);
    tick(); idle_inputs(); #1;
    check("rdw_new_a", R_Data_A, 32'h0BADBEEF);
    check("rdw_new_b", R_Data_B, 32'h0BADBEEF);
    check("rdw_new_c", R_Data_C, 32'hCAFEF00D);

    // PC load, increment with wrap, load priority, reset priority.
    Write_PC = 1'b1; PC_New = 32'hFFFFFFF8; tick(); idle_inputs(); #1;
    check("pc_load", PC, 32'hFFFFFFF8);
    M = 5'h10;
    tick(); check("pc_inc1", PC, 32'hFFFFFFFC);
    tick(); check("pc_wrap", PC, 32'h00000000);
    tick(); check("pc_inc3", PC, 32'h00000004);
    Write_PC = 1'b1; PC_New = 32'h100; tick(); #1;
    check("pc_load_prio", PC, 32'h100);
    Rst = 1'b1; Write_PC = 1'b1; PC_New = 32'hDEAD0000;
    Write_Reg = 1'b1; W_Addr = 4'd7; W_Data = 32'h55555555; M = 5'h1F;
    R_Addr_A = 4'd5; R_Addr_B = 4'd7; R_Addr_C = 4'd3;
    tick(); idle_inputs(); #1;
    check("rst_prio_pc", PC, 32'h0);
    check("rst_prio_r5", R_Data_A, 32'h0);
    check("rst_prio_r7", R_Data_B, 32'h0);
    check("rst_prio_r3", R_Data_C, 32'h0);

    // Randomized cycles against the model.
    for (int n = 0; n < 400; n++) begin
      Rst       = ($urandom_range(0, 39) == 0);
      M         = 5'($urandom_range(0, 31));
      Write_PC  = ($urandom_range(0, 7) == 0);
      PC_New    = $urandom;
      Write_Reg = ($urandom_range(0, 3) != 0);
      W_Addr    = 4'($urandom_range(0, 15));
      W_Data    = $urandom;
      R_Addr_A  = 4'($urandom_range(0, 15));
      R_Addr_B  = ($urandom_range(0, 3) == 0) ? W_Addr : 4'($urandom_range(0, 15));
      R_Addr_C  = 4'($urandom_range(0, 15));
      #1;
      check_ports("rand_pre");
      tick();
      check_ports("rand_post");
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
